vend_seq_ctrl: RTL and testbench
================================

VEND_SEQ_CTRL -- requirements
Module: vend_seq_ctrl

Interface
REQ-001 Parameter: MAX_CREDIT, 20, credit ceiling in half-yuan units (10 yuan).
REQ-002 Parameter: CHG_GAP, 2, cycles between successive change pulses, minimum 1.
REQ-003 Parameter: TIMEOUT_CYC, 1000, idle cycles before auto-cancel; used only with VEND_TIMEOUT_EN.
REQ-004 Port: sys_clk  in  1  clock, rising edge.
REQ-005 Port: sysRstN  in  1  reset, asynchronous, active-low.
REQ-006 Port: piOne  in  1  one-cycle pulse, 1-yuan coin inserted.
REQ-007 Port: piHalf  in  1  one-cycle pulse, 0.5-yuan coin inserted.
REQ-008 Port: piSelVld  in  1  one-cycle pulse, product selection valid.
REQ-009 Port: piSel  in  2  product index, sampled when piSelVld=1.
REQ-010 Port: piCancel  in  1  one-cycle pulse, refund request.
REQ-011 Port: iDispRdy  in  1  dispenser mechanism ready/accept.
REQ-012 Port: oDispReq  out  1  dispense request, held until accepted.
REQ-013 Port: oDispItem  out  2  item being dispensed, stable while oDispReq=1.
REQ-014 Port: oChangeHalf  out  1  one-cycle pulse, eject one 0.5-yuan coin.
REQ-015 Port: oCoinRej  out  1  one-cycle pulse, inserted coin refused and returned.
REQ-016 Port: oLowCredit  out  1  one-cycle pulse, selection refused for insufficient credit.
REQ-017 Port: oCredit  out  5  current credit, half-yuan units.
REQ-018 Port: oBusy  out  1  high in VEND or CHANGE.

Function
REQ-019 FSM states: IDLE, CREDIT, VEND, CHANGE; state register one-hot.
REQ-020 Coins: piOne adds 2 units, piHalf adds 1 unit; both asserted in the same cycle add 3 units; credit updates on the following edge.
REQ-021 A coin that would take credit above MAX_CREDIT is refused entirely: credit unchanged, oCoinRej pulses the next cycle (a single pulse even if both coins are refused).
REQ-022 IDLE->CREDIT on the first accepted coin; CREDIT->IDLE never occurs except through CHANGE reaching zero.
REQ-023 Selection in IDLE/CREDIT with credit >= PRICE[piSel]: latch item, go VEND, assert oDispReq the next cycle.
REQ-024 Selection with credit < PRICE[piSel]: state and credit unchanged, oLowCredit pulses the next cycle.
REQ-025 Coin and selection in the same cycle: the coin is added first, and the selection is evaluated against the updated credit.
REQ-026 VEND handshake: the transfer occurs on the cycle oDispReq=1 and iDispRdy=1; credit is reduced by the price on that edge; oDispReq drops the next cycle.
REQ-027 After the transfer: remainder > 0 -> CHANGE; remainder = 0 -> IDLE.
REQ-028 piCancel in CREDIT -> CHANGE with the full credit; piCancel in IDLE, VEND or CHANGE is ignored.
REQ-029 CHANGE: one oChangeHalf pulse per CHG_GAP cycles, with oCredit decremented by 1 per pulse; the first pulse comes on the first cycle in CHANGE; at zero credit -> IDLE.
REQ-030 Coins arriving in VEND or CHANGE are refused with oCoinRej; selections in VEND or CHANGE are ignored without oLowCredit.
REQ-031 Arithmetic is unsigned 5-bit; credit never wraps or underflows.

Reset
REQ-032 Asynchronous assertion: state=IDLE, credit=0, and all outputs are 0.
REQ-033 Reset in the middle of a vend or during change cancels the operation and discards all credit, with no change pulses.
REQ-034 Reset deassertion is synchronised externally; the first active edge after deassertion is a normal cycle.

Configuration
REQ-035 Macro VEND_TIMEOUT_EN: when defined, CREDIT with no coin, selection or cancel for TIMEOUT_CYC consecutive cycles behaves as piCancel; the counter restarts on any such event.
REQ-036 Without VEND_TIMEOUT_EN there is no timeout counter and credit is held indefinitely in CREDIT.

Structure
REQ-037 Package vend_pkg holds: the state enum, CREDIT_W=5, COIN_ONE=2, COIN_HALF=1, and the price table PRICE[0..3] = {5,3,4,6} half-units.
REQ-038 One sub-module, vend_change_dispenser: it takes a load value, counts down paced by CHG_GAP, emits oChangeHalf and signals done.

Verification
REQ-039 Directed scenario, exact payment: piOne, piOne, piHalf, then sel=0 with iDispRdy=1 -> one oDispReq transfer with item 0; credit 5->0; IDLE; no oChangeHalf.
REQ-040 Directed scenario, change: three piOne (credit 6), sel=1 -> transfer; credit 3; then 3 oChangeHalf pulses spaced CHG_GAP apart; IDLE.
REQ-041 Directed scenario, low credit and overflow: credit 2, sel=3 -> oLowCredit and credit stays 2; fill to 20, then piHalf -> oCoinRej and credit stays 20.
REQ-042 Directed scenario, handshake stall: iDispRdy=0 for 10 cycles -> oDispReq and oDispItem held steady; coin during the stall -> oCoinRej; iDispRdy=1 -> transfer.
REQ-043 Directed scenario, cancel and reset: credit 4, piCancel -> 4 oChangeHalf pulses; reset asserted after 2 pulses -> outputs 0, credit 0.
REQ-044 Directed scenario, timeout (VEND_TIMEOUT_EN defined): credit 3 with no activity for TIMEOUT_CYC cycles -> CHANGE entered, 3 oChangeHalf pulses.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequence controller: state encoding,
// credit width, coin values and the product price table (all in half-yuan units).
package vend_pkg;

  localparam int CREDIT_W = 5;

  typedef logic [CREDIT_W-1:0] credit_t;

  localparam credit_t COIN_ONE  = 5'd2;
  localparam credit_t COIN_HALF = 5'd1;

  // Index 0..3 maps directly onto piSel.
  localparam credit_t PRICE [4] = '{5'd5, 5'd3, 5'd4, 5'd6};

  typedef enum logic [3:0] {
    IDLE   = 4'b0001,
    CREDIT = 4'b0010,
    VEND   = 4'b0100,
    CHANGE = 4'b1000
  } vend_state_t;

endpackage

// File: rtl/vend_seq_ctrl_if.sv
// Bundle of the coin/selection inputs, dispenser handshake and status outputs
// of vend_seq_ctrl, plus a debug view of the controller state.
interface vend_seq_ctrl_if;
  import vend_pkg::*;

  logic        piOne;
  logic        piHalf;
  logic        piSelVld;
  logic [1:0]  piSel;
  logic        piCancel;
  // Dispenser handshake: oDispReq/oDispItem are held stable until a cycle with
  // oDispReq=1 and iDispRdy=1; that cycle is the transfer, and oDispReq drops after it.
  logic        iDispRdy;
  logic        oDispReq;
  logic [1:0]  oDispItem;
  logic        oChangeHalf;
  logic        oCoinRej;
  logic        oLowCredit;
  credit_t     oCredit;
  logic        oBusy;
  vend_state_t dbg_state;

  modport master (
    output piOne, piHalf, piSelVld, piSel, piCancel, iDispRdy,
    input  oDispReq, oDispItem, oChangeHalf, oCoinRej, oLowCredit, oCredit, oBusy, dbg_state
  );

  modport slave (
    input  piOne, piHalf, piSelVld, piSel, piCancel, iDispRdy,
    output oDispReq, oDispItem, oChangeHalf, oCoinRej, oLowCredit, oCredit, oBusy, dbg_state
  );

endinterface

// File: rtl/vend_change_dispenser.sv
// Change ejector: loads a half-yuan count and emits one chg_pulse every CHG_GAP
// cycles, the first on the cycle after load, until the count reaches zero.
module vend_change_dispenser
  import vend_pkg::*;
#(
  parameter int CHG_GAP = 2
) (
  input  logic    sys_clk,
  input  logic    sysRstN,
  input  logic    load,
  input  credit_t load_val,
  output logic    chg_pulse,
  output credit_t remaining,
  output logic    done
);

  localparam int GAP_W = (CHG_GAP > 1) ? $clog2(CHG_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(CHG_GAP - 1);

  credit_t          cnt_q;
  logic [GAP_W-1:0] gap_q;

  always_ff @(posedge sys_clk or negedge sysRstN) begin
    if (!sysRstN) begin
      cnt_q <= '0;
      gap_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
      gap_q <= '0;
    end else if (chg_pulse) begin
      cnt_q <= cnt_q - 5'd1;
      gap_q <= GAP_RELOAD;
    end else if (gap_q != '0) begin
      gap_q <= gap_q - 1'b1;
    end
  end

  assign chg_pulse = (cnt_q != '0) && (gap_q == '0);
  assign remaining = cnt_q;
  // Done on the last pulse so the controller leaves CHANGE as the count hits zero.
  assign done      = (cnt_q == '0) || (chg_pulse && (cnt_q == 5'd1));

endmodule

// File: rtl/vend_seq_ctrl.sv
// Vending sequence controller: coin credit, product selection, dispenser handshake
// and paced change refund. Optional idle auto-cancel in CREDIT under VEND_TIMEOUT_EN.
module vend_seq_ctrl
  import vend_pkg::*;
#(
  parameter int MAX_CREDIT  = 20,
  parameter int CHG_GAP     = 2,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic            sys_clk,
  input logic            sysRstN,
  vend_seq_ctrl_if.slave bus
);

  if (CHG_GAP < 1 || TIMEOUT_CYC < 1 || MAX_CREDIT > 31) begin : g_param_check
    $error("vend_seq_ctrl: parameter out of range");
  end

  localparam logic [5:0] MAX_C6 = 6'(MAX_CREDIT);

  vend_state_t state_q, state_d;
  credit_t     credit_q, credit_d, credit_eff, remainder, chg_val, chg_rem;
  logic [1:0]  item_q, item_d;
  logic        coin_rej_q, coin_rej_d, low_credit_q, low_credit_d;
  logic        chg_load, chg_pulse, chg_done, coin_ok, timeout_hit;
  logic [5:0]  coin_add, coin_sum;

  // Coins only count in IDLE/CREDIT; the sum is 6 bits wide so overflow is visible.
  assign coin_add   = (bus.piOne  ? 6'(COIN_ONE)  : 6'd0) +
                      (bus.piHalf ? 6'(COIN_HALF) : 6'd0);
  assign coin_sum   = {1'b0, credit_q} + coin_add;
  assign coin_ok    = ((state_q == IDLE) || (state_q == CREDIT)) &&
                      (coin_add != 6'd0) && (coin_sum <= MAX_C6);
  assign coin_rej_d = (coin_add != 6'd0) && !coin_ok;
  assign credit_eff = coin_ok ? coin_sum[4:0] : credit_q;
  assign remainder  = credit_q - PRICE[item_q];

`ifdef VEND_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_q;
  logic            activity;

  assign activity = bus.piOne | bus.piHalf | bus.piSelVld | bus.piCancel;

  always_ff @(posedge sys_clk or negedge sysRstN) begin
    if (!sysRstN)                               to_cnt_q <= '0;
    else if (state_q != CREDIT || activity)     to_cnt_q <= '0;
    else if (to_cnt_q != TO_LAST)               to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign timeout_hit = (state_q == CREDIT) && !activity && (to_cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  vend_change_dispenser #(.CHG_GAP(CHG_GAP)) u_change (
    .sys_clk  (sys_clk),
    .sysRstN  (sysRstN),
    .load     (chg_load),
    .load_val (chg_val),
    .chg_pulse(chg_pulse),
    .remaining(chg_rem),
    .done     (chg_done)
  );

  always_ff @(posedge sys_clk or negedge sysRstN) begin
    if (!sysRstN) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge sys_clk or negedge sysRstN) begin
    if (!sysRstN) begin
      credit_q     <= '0;
      item_q       <= '0;
      coin_rej_q   <= 1'b0;
      low_credit_q <= 1'b0;
    end else begin
      credit_q     <= credit_d;
      item_q       <= item_d;
      coin_rej_q   <= coin_rej_d;
      low_credit_q <= low_credit_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    credit_d     = credit_q;
    item_d       = item_q;
    low_credit_d = 1'b0;
    chg_load     = 1'b0;
    chg_val      = '0;
    unique case (state_q)
      IDLE, CREDIT: begin
        credit_d = credit_eff;
        if (coin_ok) state_d = CREDIT;
        // Cancel/timeout wins over a same-cycle selection; the refund includes the new coin.
        if ((state_q == CREDIT) && (bus.piCancel || timeout_hit)) begin
          state_d  = CHANGE;
          chg_load = 1'b1;
          chg_val  = credit_eff;
          credit_d = '0;
        end else if (bus.piSelVld) begin
          if (credit_eff >= PRICE[bus.piSel]) begin
            state_d = VEND;
            item_d  = bus.piSel;
          end else begin
            low_credit_d = 1'b1;
          end
        end
      end
      VEND: begin
        if (bus.iDispRdy) begin
          credit_d = '0;
          if (remainder != '0) begin
            state_d  = CHANGE;
            chg_load = 1'b1;
            chg_val  = remainder;
          end else begin
            state_d = IDLE;
          end
        end
      end
      CHANGE: begin
        if (chg_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.oDispReq    = (state_q == VEND);
    bus.oDispItem   = item_q;
    bus.oChangeHalf = (state_q == CHANGE) && chg_pulse;
    bus.oCoinRej    = coin_rej_q;
    bus.oLowCredit  = low_credit_q;
    bus.oCredit     = (state_q == CHANGE) ? chg_rem : credit_q;
    bus.oBusy       = (state_q == VEND) || (state_q == CHANGE);
    bus.dbg_state   = state_q;
  end

endmodule

// File: tb/tb_vend_seq_ctrl.sv
// Directed bench for vend_seq_ctrl; define VEND_TIMEOUT_EN to exercise auto-cancel.
module tb_vend_seq_ctrl;
  import vend_pkg::*;

  localparam int MAXC = 20;
  localparam int GAP  = 2;
  localparam int TO   = 20;

  logic sys_clk = 1'b0;
  logic sysRstN = 1'b0;
  int   cyc = 0;

  vend_seq_ctrl_if vif ();

  vend_seq_ctrl #(.MAX_CREDIT(MAXC), .CHG_GAP(GAP), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(sys_clk),
    .sysRstN(sysRstN),
    .bus    (vif)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int chg_cnt, xfer_cnt, rej_cnt, low_cnt, gap_bad, last_chg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
  endtask

  always @(negedge sys_clk) begin
    if (vif.oChangeHalf) begin
      if (chg_cnt != 0 && (cyc - last_chg) != GAP) gap_bad++;
      last_chg = cyc;
      chg_cnt++;
    end
    if (vif.oDispReq && vif.iDispRdy) xfer_cnt++;
    if (vif.oCoinRej)   rej_cnt++;
    if (vif.oLowCredit) low_cnt++;
  end

  task automatic clear_counts();
    chg_cnt = 0; xfer_cnt = 0; rej_cnt = 0; low_cnt = 0; gap_bad = 0; last_chg = 0;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic coin(input logic one, input logic half);
    vif.piOne = one; vif.piHalf = half;
    tick();
    vif.piOne = 1'b0; vif.piHalf = 1'b0;
  endtask

  task automatic select(input logic [1:0] s);
    vif.piSelVld = 1'b1; vif.piSel = s;
    tick();
    vif.piSelVld = 1'b0;
  endtask

  task automatic cancel();
    vif.piCancel = 1'b1;
    tick();
    vif.piCancel = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (vif.dbg_state !== IDLE && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(vif.dbg_state), 32'(IDLE));
  endtask

  task automatic do_reset();
    sysRstN = 1'b0;
    vif.piOne = 1'b0; vif.piHalf = 1'b0; vif.piSelVld = 1'b0;
    vif.piSel = 2'd0; vif.piCancel = 1'b0; vif.iDispRdy = 1'b1;
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sysRstN = 1'b1;
    clear_counts();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_counts();
    do_reset();
    check("rst_credit", 32'(vif.oCredit), 0);
    check("rst_req",    32'(vif.oDispReq), 0);
    check("rst_busy",   32'(vif.oBusy), 0);
    check("rst_state",  32'(vif.dbg_state), 32'(IDLE));

    // Exact payment: 2+2+1 = 5 = PRICE[0], no change.
    coin(1, 0); check("exact_c2", 32'(vif.oCredit), 2);
    check("exact_st_credit", 32'(vif.dbg_state), 32'(CREDIT));
    coin(1, 0); check("exact_c4", 32'(vif.oCredit), 4);
    coin(0, 1); check("exact_c5", 32'(vif.oCredit), 5);
    select(2'd0);
    check("exact_req",  32'(vif.oDispReq), 1);
    check("exact_item", 32'(vif.oDispItem), 0);
    check("exact_busy", 32'(vif.oBusy), 1);
    tick();
    check("exact_req_drop", 32'(vif.oDispReq), 0);
    check("exact_credit0",  32'(vif.oCredit), 0);
    check("exact_idle",     32'(vif.dbg_state), 32'(IDLE));
    repeat (4) tick();
    check("exact_xfers", 32'(xfer_cnt), 1);
    check("exact_nochg", 32'(chg_cnt), 0);

    // Change: credit 6, item 1 costs 3, refund 3 half-coins spaced GAP apart.
    clear_counts();
    repeat (3) coin(1, 0);
    check("chg_c6", 32'(vif.oCredit), 6);
    select(2'd1);
    check("chg_req", 32'(vif.oDispReq), 1);
    tick();
    check("chg_state",  32'(vif.dbg_state), 32'(CHANGE));
    check("chg_credit3", 32'(vif.oCredit), 3);
    check("chg_first_pulse", 32'(vif.oChangeHalf), 1);
    tick();
    check("chg_after_first", 32'(vif.oCredit), 2);
    wait_idle("chg_idle", 20);
    check("chg_pulses", 32'(chg_cnt), 3);
    check("chg_gap",    32'(gap_bad), 0);
    check("chg_credit0", 32'(vif.oCredit), 0);
    check("chg_xfers",  32'(xfer_cnt), 1);

    // Low credit then overflow at the ceiling.
    clear_counts();
    coin(1, 0);
    select(2'd3);
    check("low_pulse",  32'(vif.oLowCredit), 1);
    check("low_credit", 32'(vif.oCredit), 2);
    check("low_state",  32'(vif.dbg_state), 32'(CREDIT));
    repeat (9) coin(1, 0);
    check("ovf_full", 32'(vif.oCredit), 20);
    check("ovf_norej_at_max", 32'(rej_cnt), 0);
    coin(0, 1);
    check("ovf_rej",    32'(vif.oCoinRej), 1);
    check("ovf_credit", 32'(vif.oCredit), 20);
    coin(1, 1);
    tick();
    check("ovf_rej_single", 32'(rej_cnt), 2);
    check("ovf_credit2",    32'(vif.oCredit), 20);
    check("low_count",      32'(low_cnt), 1);
    do_reset();
    check("ovf_rst_credit", 32'(vif.oCredit), 0);

    // Handshake stall with a coin and a selection arriving mid-stall.
    vif.iDispRdy = 1'b0;
    coin(1, 0); coin(1, 0); coin(0, 1);
    select(2'd2);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) vif.piOne = 1'b1;
      if (i == 6) begin vif.piSelVld = 1'b1; vif.piSel = 2'd0; end
      tick();
      vif.piOne = 1'b0; vif.piSelVld = 1'b0;
      check($sformatf("stall_req%0d", i),  32'(vif.oDispReq), 1);
      check($sformatf("stall_item%0d", i), 32'(vif.oDispItem), 2);
    end
    check("stall_rej",    32'(rej_cnt), 1);
    check("stall_nolow",  32'(low_cnt), 0);
    check("stall_credit", 32'(vif.oCredit), 5);
    check("stall_noxfer", 32'(xfer_cnt), 0);
    vif.iDispRdy = 1'b1;
    tick();
    check("stall_chg_state", 32'(vif.dbg_state), 32'(CHANGE));
    check("stall_rem",       32'(vif.oCredit), 1);
    wait_idle("stall_idle", 20);
    check("stall_xfer",   32'(xfer_cnt), 1);
    check("stall_pulses", 32'(chg_cnt), 1);

    // Cancel ignored in IDLE, honoured in CREDIT; reset mid-refund.
    clear_counts();
    cancel();
    check("cancel_idle_st", 32'(vif.dbg_state), 32'(IDLE));
    check("cancel_idle_busy", 32'(vif.oBusy), 0);
    coin(1, 0); coin(1, 0);
    cancel();
    check("cancel_state",  32'(vif.dbg_state), 32'(CHANGE));
    check("cancel_credit", 32'(vif.oCredit), 4);
    tick(); tick();
    @(negedge sys_clk); #1;
    check("cancel_two_pulses", 32'(chg_cnt), 2);
    sysRstN = 1'b0;
    #1;
    check("arst_credit", 32'(vif.oCredit), 0);
    check("arst_chg",    32'(vif.oChangeHalf), 0);
    check("arst_req",    32'(vif.oDispReq), 0);
    check("arst_busy",   32'(vif.oBusy), 0);
    check("arst_rej",    32'(vif.oCoinRej), 0);
    check("arst_low",    32'(vif.oLowCredit), 0);
    check("arst_state",  32'(vif.dbg_state), 32'(IDLE));
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    sysRstN = 1'b1;
    tick(); tick();
    check("arst_no_more_pulses", 32'(chg_cnt), 2);
    check("arst_post_credit",    32'(vif.oCredit), 0);

    // Both coins in one cycle, then idle in CREDIT.
    clear_counts();
    coin(1, 1);
    check("both_c3", 32'(vif.oCredit), 3);
`ifdef VEND_TIMEOUT_EN
    repeat (TO - 1) tick();
    check("to_before", 32'(vif.dbg_state), 32'(CREDIT));
    tick();
    check("to_change", 32'(vif.dbg_state), 32'(CHANGE));
    check("to_credit", 32'(vif.oCredit), 3);
`else
    repeat (TO + 5) tick();
    check("hold_state",  32'(vif.dbg_state), 32'(CREDIT));
    check("hold_credit", 32'(vif.oCredit), 3);
    cancel();
`endif
    wait_idle("refund_idle", 20);
    check("refund_pulses", 32'(chg_cnt), 3);
    check("refund_gap",    32'(gap_bad), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
